// File: rtl/llc_way_select_pipe_pkg.sv
// Shared state encodings, selection result type and rotated priority search
// used by the LLC way-select pipeline.
package llc_pipe_pkg;

    // Upper bound on WAYS supported by the rotated search below.
    localparam int MAX_WAYS     = 64;
    localparam int MAX_WAY_BITS = 6;

    localparam logic [2:0] ST_INVALID = 3'd0;
    localparam logic [2:0] ST_VALID   = 3'd1;
    localparam logic [2:0] ST_SHARED  = 3'd2;
    localparam logic [2:0] ST_SD      = 3'd3;

    typedef struct packed {
        logic [MAX_WAY_BITS-1:0] way;
        logic                    hit;
        logic                    evict;
        logic                    no_way;
    } llc_way_sel_t;

    // First set bit of vec visiting (start + k) mod ways; idx = start when none is set.
    function automatic logic rot_first(input  logic [MAX_WAYS-1:0] vec,
                                       input  int                  start,
                                       input  int                  ways,
                                       output int                  idx);
        logic found;
        int   pos;
        found = 1'b0;
        idx   = start;
        pos   = 0;
        for (int k = 0; k < MAX_WAYS; k++) begin
            pos = (start + k) & (ways - 1);
            if (!found && (k < ways) && vec[MAX_WAY_BITS'(pos)]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/llc_way_select_pipe_if.sv
// Request/response bus of the LLC way-select pipeline: the SRAM read stage
// drives requests, the LLC main controller consumes responses.
interface llc_way_select_pipe_if #(
    parameter int WAYS       = 16,
    parameter int WAY_BITS   = $clog2(WAYS),
    parameter int TAG_BITS   = 20,
    parameter int STATE_BITS = 3,
    parameter int ID_BITS    = 4
);
    logic                       req_valid;
    logic                       req_ready;
    logic [TAG_BITS-1:0]        req_tag;
    logic [WAYS*TAG_BITS-1:0]   req_tags;
    logic [WAYS*STATE_BITS-1:0] req_states;
    logic [WAY_BITS-1:0]        req_evict_start;
    logic [WAYS-1:0]            req_lock_mask;
    logic [ID_BITS-1:0]         req_id;
    logic                       resp_valid;
    logic                       resp_ready;
    logic [WAY_BITS-1:0]        resp_way;
    logic                       resp_hit;
    logic                       resp_evict;
    logic                       resp_no_way;
    logic [ID_BITS-1:0]         resp_id;

    modport master (
        output req_valid, req_tag, req_tags, req_states, req_evict_start,
               req_lock_mask, req_id, resp_ready,
        input  req_ready, resp_valid, resp_way, resp_hit, resp_evict,
               resp_no_way, resp_id
    );

    modport slave (
        input  req_valid, req_tag, req_tags, req_states, req_evict_start,
               req_lock_mask, req_id, resp_ready,
        output req_ready, resp_valid, resp_way, resp_hit, resp_evict,
               resp_no_way, resp_id
    );
endinterface

// File: rtl/llc_way_select_pipe_rot_prio_enc.sv
// Rotated priority encoder: first set bit of vec scanning upward from start
// with wrap-around.
module llc_rot_prio_enc
    import llc_pipe_pkg::*;
#(
    parameter int WAYS     = 16,
    parameter int WAY_BITS = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]     vec,
    input  logic [WAY_BITS-1:0] start,
    output logic [WAY_BITS-1:0] idx,
    output logic                found
);

    int idx_s;

    always_comb begin
        idx_s = 0;
        found = rot_first(MAX_WAYS'(vec), int'(start), WAYS, idx_s);
        idx   = WAY_BITS'(idx_s);
    end

endmodule

// File: rtl/llc_way_select_pipe.sv
// Two-stage way selection for the LLC: S1 classifies every way of the set,
// S2 picks hit / empty / victim / none and holds the response.
module llc_way_select_pipe
    import llc_pipe_pkg::*;
#(
    parameter int WAYS       = 16,
    parameter int WAY_BITS   = $clog2(WAYS),
    parameter int TAG_BITS   = 20,
    parameter int STATE_BITS = 3,
    parameter int ID_BITS    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    llc_way_select_pipe_if.slave bus
);

    logic                  s2_load_s, s1_load_s, accept_s;
    logic [TAG_BITS-1:0]   way_tag_s;
    logic [STATE_BITS-1:0] way_state_s;
    logic [WAYS-1:0]       hit_s, empty_s, vvalid_s, nsd_s, free_s;

    logic                  s1_valid_r;
    logic [WAYS-1:0]       s1_hit_r, s1_empty_r, s1_vvalid_r, s1_nsd_r, s1_free_r;
    logic [WAY_BITS-1:0]   s1_start_r;
    logic [ID_BITS-1:0]    s1_id_r;

    logic                  any_hit_s, low_found_s;
    logic [WAYS-1:0]       low_vec_s;
    logic [WAY_BITS-1:0]   low_idx_s, vv_idx_s, nsd_idx_s, free_idx_s;
    logic                  vv_found_s, nsd_found_s, free_found_s;
    llc_way_sel_t          sel_s;

    logic                  s2_valid_r;
    llc_way_sel_t          s2_sel_r;
    logic [ID_BITS-1:0]    s2_id_r;

    // A stage advances when the stage after it is empty or is itself advancing.
    always_comb begin
        s2_load_s = !s2_valid_r || bus.resp_ready;
        s1_load_s = !s1_valid_r || s2_load_s;
        accept_s  = bus.req_valid && s1_load_s && !flush;
    end

    assign bus.req_ready = s1_load_s && !flush;

    // Per-way classification of the incoming set.
    always_comb begin
        hit_s       = '0;
        empty_s     = '0;
        vvalid_s    = '0;
        nsd_s       = '0;
        free_s      = '0;
        way_tag_s   = '0;
        way_state_s = '0;
        for (int i = 0; i < WAYS; i++) begin
            way_tag_s   = bus.req_tags[i*TAG_BITS +: TAG_BITS];
            way_state_s = bus.req_states[i*STATE_BITS +: STATE_BITS];
            hit_s[i]    = (way_tag_s == bus.req_tag) &&
                          (way_state_s != STATE_BITS'(ST_INVALID));
            empty_s[i]  = (way_state_s == STATE_BITS'(ST_INVALID)) && !bus.req_lock_mask[i];
            vvalid_s[i] = (way_state_s == STATE_BITS'(ST_VALID)) && !bus.req_lock_mask[i];
            nsd_s[i]    = (way_state_s != STATE_BITS'(ST_SD)) && !bus.req_lock_mask[i];
            free_s[i]   = !bus.req_lock_mask[i];
        end
    end

    // S1 register: holds its contents while the downstream stage is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r  <= 1'b0;
            s1_hit_r    <= '0;
            s1_empty_r  <= '0;
            s1_vvalid_r <= '0;
            s1_nsd_r    <= '0;
            s1_free_r   <= '0;
            s1_start_r  <= '0;
            s1_id_r     <= '0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
        end else if (s1_load_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_hit_r    <= hit_s;
                s1_empty_r  <= empty_s;
                s1_vvalid_r <= vvalid_s;
                s1_nsd_r    <= nsd_s;
                s1_free_r   <= free_s;
                s1_start_r  <= bus.req_evict_start;
                s1_id_r     <= bus.req_id;
            end
        end
    end

    // Hit and empty share one lowest-index encoder since hit always wins.
    always_comb begin
        any_hit_s   = |s1_hit_r;
        low_vec_s   = any_hit_s ? s1_hit_r : s1_empty_r;
        low_found_s = |low_vec_s;
        low_idx_s   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            low_idx_s = low_vec_s[i] ? WAY_BITS'(i) : low_idx_s;
        end
    end

    llc_rot_prio_enc #(.WAYS(WAYS), .WAY_BITS(WAY_BITS)) u_enc_vvalid (
        .vec(s1_vvalid_r), .start(s1_start_r), .idx(vv_idx_s), .found(vv_found_s)
    );

    llc_rot_prio_enc #(.WAYS(WAYS), .WAY_BITS(WAY_BITS)) u_enc_nsd (
        .vec(s1_nsd_r), .start(s1_start_r), .idx(nsd_idx_s), .found(nsd_found_s)
    );

    llc_rot_prio_enc #(.WAYS(WAYS), .WAY_BITS(WAY_BITS)) u_enc_free (
        .vec(s1_free_r), .start(s1_start_r), .idx(free_idx_s), .found(free_found_s)
    );

    // Victim preference: clean VALID, then anything not SD, then any unlocked way.
    always_comb begin
        sel_s = '0;
        if (low_found_s) begin
            sel_s.way = MAX_WAY_BITS'(low_idx_s);
            sel_s.hit = any_hit_s;
        end else if (vv_found_s) begin
            sel_s.way   = MAX_WAY_BITS'(vv_idx_s);
            sel_s.evict = 1'b1;
        end else if (nsd_found_s) begin
            sel_s.way   = MAX_WAY_BITS'(nsd_idx_s);
            sel_s.evict = 1'b1;
        end else if (free_found_s) begin
            sel_s.way   = MAX_WAY_BITS'(free_idx_s);
            sel_s.evict = 1'b1;
        end else begin
            sel_s.way    = MAX_WAY_BITS'(s1_start_r);
            sel_s.no_way = 1'b1;
        end
    end

    // S2 register: the response stays frozen until the consumer takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_r <= 1'b0;
            s2_sel_r   <= '0;
            s2_id_r    <= '0;
        end else if (flush) begin
            s2_valid_r <= 1'b0;
        end else if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_sel_r <= sel_s;
                s2_id_r  <= s1_id_r;
            end
        end
    end

    assign bus.resp_valid  = s2_valid_r;
    assign bus.resp_way    = WAY_BITS'(s2_sel_r.way);
    assign bus.resp_hit    = s2_sel_r.hit;
    assign bus.resp_evict  = s2_sel_r.evict;
    assign bus.resp_no_way = s2_sel_r.no_way;
    assign bus.resp_id     = s2_id_r;

endmodule

// File: tb/tb_llc_way_select_pipe.sv
// Directed scoreboard bench for llc_way_select_pipe: expected responses are
// queued on acceptance and compared in order as responses are consumed.
module tb_llc_way_select_pipe;
    import llc_pipe_pkg::*;

    localparam int WAYS       = 16;
    localparam int WAY_BITS   = 4;
    localparam int TAG_BITS   = 20;
    localparam int STATE_BITS = 3;
    localparam int ID_BITS    = 4;

    typedef struct packed {
        logic [WAY_BITS-1:0] way;
        logic                hit;
        logic                evict;
        logic                no_way;
        logic [ID_BITS-1:0]  id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [TAG_BITS-1:0]   t_tags   [WAYS];
    logic [STATE_BITS-1:0] t_states [WAYS];

    llc_way_select_pipe_if #(.WAYS(WAYS), .WAY_BITS(WAY_BITS), .TAG_BITS(TAG_BITS),
                             .STATE_BITS(STATE_BITS), .ID_BITS(ID_BITS)) bus ();

    llc_way_select_pipe #(.WAYS(WAYS), .WAY_BITS(WAY_BITS), .TAG_BITS(TAG_BITS),
                          .STATE_BITS(STATE_BITS), .ID_BITS(ID_BITS)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input int way, input logic hit, input logic evict,
                                input logic no_way, input int id);
        exp_t e;
        e.way    = WAY_BITS'(way);
        e.hit    = hit;
        e.evict  = evict;
        e.no_way = no_way;
        e.id     = ID_BITS'(id);
        return e;
    endfunction

    task automatic set_all(input logic [TAG_BITS-1:0] tg, input logic [2:0] st);
        for (int i = 0; i < WAYS; i++) begin
            t_tags[i]   = tg;
            t_states[i] = STATE_BITS'(st);
        end
    endtask

    task automatic drive_set();
        for (int i = 0; i < WAYS; i++) begin
            bus.req_tags[i*TAG_BITS +: TAG_BITS]       = t_tags[i];
            bus.req_states[i*STATE_BITS +: STATE_BITS] = t_states[i];
        end
    endtask

    // Present one request, hold it until accepted (bounded), queue its expectation.
    task automatic send(input logic [TAG_BITS-1:0] tag, input int start,
                        input logic [WAYS-1:0] lock, input exp_t expv);
        logic acc;
        int   budget;
        drive_set();
        bus.req_tag         = tag;
        bus.req_evict_start = WAY_BITS'(start);
        bus.req_lock_mask   = lock;
        bus.req_id          = expv.id;
        bus.req_valid       = 1'b1;
        acc    = 1'b0;
        budget = 0;
        while (!acc && budget < 50) begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk);
            budget++;
        end
        check("accept_in_budget", 64'(acc), 64'd1);
        if (acc) sb.push_back(expv);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    // Response monitor and req_ready rule, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t got;
        exp_t want;
        if (rst) begin
            check("req_ready_rule", 64'(bus.req_ready),
                  64'(!flush && !(sb.size() == 2 && !bus.resp_ready)));
            if (bus.resp_valid && bus.resp_ready) begin
                check("resp_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    want       = sb.pop_front();
                    got.way    = bus.resp_way;
                    got.hit    = bus.resp_hit;
                    got.evict  = bus.resp_evict;
                    got.no_way = bus.resp_no_way;
                    got.id     = bus.resp_id;
                    check("resp_way_hit_evict_noway_id", 64'(got), 64'(want));
                end
            end
        end
    end

    initial begin
        rst                 = 1'b0;
        flush               = 1'b0;
        bus.req_valid       = 1'b0;
        bus.req_tag         = '0;
        bus.req_evict_start = '0;
        bus.req_lock_mask   = '0;
        bus.req_id          = '0;
        bus.resp_ready      = 1'b1;
        set_all(20'h00000, ST_INVALID);
        drive_set();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_fields", 64'({bus.resp_way, bus.resp_hit, bus.resp_evict,
                                      bus.resp_no_way, bus.resp_id}), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Hit on a locked way, INVALID copy of the tag ignored; 2-cycle latency.
        set_all(20'h00000, ST_VALID);
        t_tags[5]   = 20'h001A3;
        t_tags[2]   = 20'h001A3;
        t_states[2] = STATE_BITS'(ST_INVALID);
        send(20'h001A3, 0, 16'h0020, mk(5, 1'b1, 1'b0, 1'b0, 1));
        check("latency_s1_not_visible", 64'(bus.resp_valid), 64'd0);
        @(posedge clk);
        #1;
        check("latency_s2_visible", 64'(bus.resp_valid), 64'd1);
        wait_drain();

        // Empty ways 3 (locked) and 9.
        set_all(20'h00055, ST_VALID);
        t_states[3] = STATE_BITS'(ST_INVALID);
        t_states[9] = STATE_BITS'(ST_INVALID);
        send(20'h001A3, 0, 16'h0008, mk(9, 1'b0, 1'b0, 1'b0, 2));
        // All VALID: rotated victim with lock and wrap.
        set_all(20'h00055, ST_VALID);
        send(20'h001A3, 14, 16'hC000, mk(0, 1'b0, 1'b1, 1'b0, 3));
        send(20'h001A3, 15, 16'h0000, mk(15, 1'b0, 1'b1, 1'b0, 4));
        // SD-heavy sets.
        set_all(20'h00055, ST_SD);
        t_states[7] = STATE_BITS'(ST_SHARED);
        send(20'h001A3, 10, 16'h0000, mk(7, 1'b0, 1'b1, 1'b0, 5));
        set_all(20'h00055, ST_SD);
        send(20'h001A3, 4, 16'hFFFE, mk(0, 1'b0, 1'b1, 1'b0, 6));
        send(20'h001A3, 4, 16'hFFFF, mk(4, 1'b0, 1'b0, 1'b1, 7));
        // Lowest-index hit with everything locked.
        t_tags[11] = 20'h001A3;
        t_tags[3]  = 20'h001A3;
        send(20'h001A3, 9, 16'hFFFF, mk(3, 1'b1, 1'b0, 1'b0, 8));
        // Empty selection is lowest-index, not rotated.
        set_all(20'h00055, ST_VALID);
        t_states[12] = STATE_BITS'(ST_INVALID);
        t_states[6]  = STATE_BITS'(ST_INVALID);
        send(20'h001A3, 8, 16'h0000, mk(6, 1'b0, 1'b0, 1'b0, 9));
        // VALID victim preferred over a nearer non-SD way.
        set_all(20'h00055, ST_SD);
        t_states[2]  = STATE_BITS'(ST_VALID);
        t_states[13] = STATE_BITS'(ST_SHARED);
        send(20'h001A3, 5, 16'h0000, mk(2, 1'b0, 1'b1, 1'b0, 10));
        wait_drain();

        // Back-to-back stream against a stalling consumer.
        set_all(20'h00000, ST_VALID);
        for (int w = 0; w < WAYS; w++) t_tags[w] = 20'h00100 + 20'(w);
        fork
            begin
                for (int r = 0; r < 8; r++)
                    send(20'h00100 + 20'(r), r, 16'h0000, mk(r, 1'b1, 1'b0, 1'b0, r));
            end
            begin
                for (int c = 0; c < 24; c++) begin
                    bus.resp_ready = (c % 3 == 0);
                    @(posedge clk);
                    #1;
                end
                bus.resp_ready = 1'b1;
            end
        join
        wait_drain();

        // Flush with two in flight; the request presented alongside is dropped.
        bus.resp_ready = 1'b0;
        set_all(20'h00055, ST_VALID);
        send(20'h001A3, 1, 16'h0000, mk(1, 1'b0, 1'b1, 1'b0, 11));
        send(20'h001A3, 2, 16'h0000, mk(2, 1'b0, 1'b1, 1'b0, 12));
        check("flush_two_in_flight", 64'(sb.size()), 64'd2);
        flush         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_id    = 4'd14;
        @(posedge clk);
        #1;
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        sb.delete();
        check("flush_resp_valid", 64'(bus.resp_valid), 64'd0);
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush_dropped_req", 64'(bus.resp_valid), 64'd0);

        // Async reset with two in flight.
        bus.resp_ready = 1'b0;
        send(20'h001A3, 3, 16'h0000, mk(3, 1'b0, 1'b1, 1'b0, 13));
        send(20'h001A3, 4, 16'h0000, mk(4, 1'b0, 1'b1, 1'b0, 14));
        rst = 1'b0;
        #1;
        check("reset_resp_valid_now", 64'(bus.resp_valid), 64'd0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("reset_req_ready", 64'(bus.req_ready), 64'd1);
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_no_stale_resp", 64'(bus.resp_valid), 64'd0);

        // Pipeline still works after reset.
        set_all(20'h00000, ST_VALID);
        t_tags[5] = 20'h001A3;
        send(20'h001A3, 0, 16'h0000, mk(5, 1'b1, 1'b0, 1'b0, 15));
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/llc_way_select_pipe.md
Name: llc_way_select_pipe

Overview:
- Pipelined, parametrised way-selection engine for the LLC.
- Per request, it compares a lookup tag against all ways of a set and returns one of: the hit way, an empty way, or an eviction victim.
- Victim search starts from a rotating start pointer and skips ways locked by in-flight transactions.
- Sits between the tag/state SRAM read stage and the LLC main controller. Fully pipelined with valid/ready handshakes on both sides, throughput 1 request/cycle.

Parameters:
- WAYS, 16, ways per set; power of two, >= 2
- WAY_BITS, $clog2(WAYS), way index width
- TAG_BITS, 20, tag width
- STATE_BITS, 3, per-way coherence state width
- ID_BITS, 4, opaque request id carried to the response

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous pipeline clear
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid & ready
- req_tag  in  TAG_BITS  lookup tag
- req_tags  in  WAYS*TAG_BITS  set tags; way i at bits [i*TAG_BITS +: TAG_BITS]
- req_states  in  WAYS*STATE_BITS  set states, same packing
- req_evict_start  in  WAY_BITS  rotation start for victim search
- req_lock_mask  in  WAYS  1 = way excluded from empty/victim selection
- req_id  in  ID_BITS  request id
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts the response
- resp_way  out  WAY_BITS  selected way
- resp_hit  out  1  tag hit
- resp_evict  out  1  selected way must be evicted
- resp_no_way  out  1  no selectable way; requester must retry
- resp_id  out  ID_BITS  echoed id

Behaviour:
- Reset (rst low, async): s1_valid=0, s2_valid=0; all response outputs 0; req_ready=1 on the first cycle after reset release.
- Stage S1 registers on acceptance: req_tag, req_evict_start, req_id, and the per-way vectors:
  - hit[i] = tag match & state != INVALID
  - empty[i] = (state == INVALID) & !lock[i]
  - vvalid[i] = (state == VALID) & !lock[i]
  - nsd[i] = (state != SD) & !lock[i]
  - free[i] = !lock[i]
- Stage S2 registers the selection. Response is visible 2 cycles after acceptance; zero bubbles under continuous resp_ready.
- Advance rules:
  - s2 loads when !s2_valid | resp_ready.
  - s1 loads when !s1_valid | s2 loads.
  - req_ready = !s1_valid | s2 loads.
  - Stalled stages hold all contents unchanged.
- Selection priority, first match wins:
  1. any hit -> lowest-index hit way; hit=1, evict=0. Lock mask is ignored for hits.
  2. any empty -> lowest-index empty way; evict=0.
  3. any vvalid -> first set way scanning (start + k) mod WAYS for k = 0..WAYS-1; evict=1.
  4. any nsd -> same rotated scan; evict=1.
  5. any free -> same rotated scan; evict=1.
  6. otherwise -> no_way=1, way=start, evict=0, hit=0.
- Exactly one of {hit, no_way, empty-select, evict} is asserted; hit, evict and no_way are mutually exclusive.
- Rotation arithmetic is WAY_BITS wide and wraps naturally; start = WAYS-1 scans WAYS-1, 0, 1, and so on.
- flush: clears s1_valid and s2_valid next edge. A request presented during a flush cycle is dropped (req_ready=0 while flush).
- Simultaneous accept + resp fire: both occur; no loss, no duplication.
- resp_* holds stable while resp_valid & !resp_ready.

Decomposition:
- Shared package llc_pipe_pkg holds:
  - state encodings (INVALID, VALID, SD constants)
  - the llc_way_sel_t struct {way, hit, evict, no_way}
  - function rot_first(vec, start), the rotated priority encoder
- One sub-module, llc_rot_prio_enc: parametrised WAYS, inputs vec and start, outputs idx and found. It is instantiated three times in S2, plus one plain lowest-index encoder shared by hit and empty.

Test Plan:
- WAYS=16, way 5 tag 0x1A3 VALID, way 2 tag 0x1A3 INVALID, req_tag 0x1A3, lock_mask=0x0020 -> resp_way=5, hit=1, evict=0, 2 cycles after acceptance.
- No hit, ways 3 and 9 INVALID, lock_mask bit 3 set -> way=9, evict=0.
- All 16 ways VALID, start=14, lock_mask bits 14,15 set -> way=0, evict=1. Same with start=15, lock=0 -> way=15.
- All ways SD except way 7 SHARED, start=10 -> way=7, evict=1. All SD, lock=0xFFFE, start=4 -> way=0, evict=1. All SD, lock=0xFFFF -> no_way=1, way=4.
- Back-to-back 8 requests with resp_ready toggling 1,0,0,1,... -> responses in order, ids 0..7, no drop or duplicate. req_ready deasserts only when both stages are full and stalled.
- Assert rst low mid-stream with 2 in flight -> resp_valid=0 immediately, no stale response after release. flush with 2 in flight -> next edge resp_valid=0, and the request presented that cycle is not accepted.
